// File: rtl/yolo_max_pool_top_hls_deadlock_reporter_if.sv
// Signal bundle between the deadlock reporter and its surroundings.
// master: reporter side (drives flags and the report stream).
// slave : monitor/logger side.
// Optional macro YOLO_DEADLOCK_AUTO_REARM_EN adds the event_cnt output.
interface yolo_max_pool_top_hls_deadlock_reporter_if #(
  parameter int NUM_MON = 2,
  parameter int CNT_W   = 32
);
  logic [NUM_MON-1:0] mon_block;
  logic               clear;
  logic               deadlock_detected;
  logic [NUM_MON-1:0] deadlock_mask;
  logic [CNT_W-1:0]   stall_cycles;
  logic               rpt_valid;
  logic               rpt_ready;
  logic [31:0]        rpt_data;
  logic               rpt_last;
`ifdef YOLO_DEADLOCK_AUTO_REARM_EN
  logic [7:0]         event_cnt;

  modport master (
    input  mon_block, clear, rpt_ready,
    output deadlock_detected, deadlock_mask, stall_cycles,
           rpt_valid, rpt_data, rpt_last, event_cnt
  );
  modport slave (
    output mon_block, clear, rpt_ready,
    input  deadlock_detected, deadlock_mask, stall_cycles,
           rpt_valid, rpt_data, rpt_last, event_cnt
  );
`else
  modport master (
    input  mon_block, clear, rpt_ready,
    output deadlock_detected, deadlock_mask, stall_cycles,
           rpt_valid, rpt_data, rpt_last
  );
  modport slave (
    output mon_block, clear, rpt_ready,
    input  deadlock_detected, deadlock_mask, stall_cycles,
           rpt_valid, rpt_data, rpt_last
  );
`endif
endinterface

// File: rtl/yolo_max_pool_top_hls_deadlock_reporter.sv
// Deadlock reporter: qualifies HLS monitor block flags over THRESH
// consecutive cycles, latches which monitors were stuck, and sends a
// 3-word report (DEAD|mask, stall count, timestamp) on a valid/ready stream.
// Optional macro YOLO_DEADLOCK_AUTO_REARM_EN: HOLD self-clears when all
// blocks drop, and a saturating 8-bit detection event counter is exported.
module yolo_max_pool_top_hls_deadlock_reporter #(
  parameter int NUM_MON = 2,
  parameter int THRESH  = 1024,
  parameter int CNT_W   = 32
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  yolo_max_pool_top_hls_deadlock_reporter_if.master bus
);
  typedef enum logic [1:0] {IDLE, WATCH, REPORT, HOLD} state_t;

  localparam logic [CNT_W:0]   THR_X   = (CNT_W+1)'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   ts_q, ts_d;
  logic               det_q, det_d;
  logic [NUM_MON-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   w1_q, w1_d;
  logic [CNT_W-1:0]   w2_q, w2_d;
  logic [1:0]         beat_q, beat_d;
  logic               vld_q, vld_d;
`ifdef YOLO_DEADLOCK_AUTO_REARM_EN
  logic [7:0]         evt_q, evt_d;
`endif

  logic             any_blk;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;

  assign any_blk = |bus.mon_block;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  // Wide compare so THRESH never aliases against a wrapped counter.
  assign hit     = ({1'b0, cnt_q} + (CNT_W+1)'(1)) == THR_X;

  // Next-state, counter and report-latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ts_d    = ts_q + CNT_W'(1);
    det_d   = det_q;
    mask_d  = mask_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    beat_d  = beat_q;
    vld_d   = vld_q;
`ifdef YOLO_DEADLOCK_AUTO_REARM_EN
    evt_d   = evt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_blk) begin
          state_d = WATCH;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d   = '0;
        end
      end
      WATCH: begin
        if (!any_blk || bus.clear) begin
          // clear wins over a detection landing on the same edge
          state_d = IDLE;
          cnt_d   = '0;
        end else if (hit) begin
          state_d = REPORT;
          cnt_d   = cnt_inc;
          det_d   = 1'b1;
          mask_d  = bus.mon_block;
          w1_d    = cnt_inc;
          w2_d    = ts_q;
          beat_d  = 2'd0;
          vld_d   = 1'b1;
`ifdef YOLO_DEADLOCK_AUTO_REARM_EN
          evt_d   = (evt_q == 8'hFF) ? evt_q : evt_q + 8'd1;
`endif
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      REPORT: begin
        if (any_blk) cnt_d = cnt_inc;
        if (vld_q && bus.rpt_ready) begin
          if (beat_q == 2'd2) begin
            vld_d   = 1'b0;
            beat_d  = 2'd0;
            state_d = HOLD;
          end else begin
            beat_d  = beat_q + 2'd1;
          end
        end
      end
      HOLD: begin
        if (any_blk) cnt_d = cnt_inc;
`ifdef YOLO_DEADLOCK_AUTO_REARM_EN
        if (bus.clear || !any_blk) begin
`else
        if (bus.clear) begin
`endif
          state_d = IDLE;
          det_d   = 1'b0;
          mask_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight report.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ts_q    <= '0;
      det_q   <= 1'b0;
      mask_q  <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      beat_q  <= 2'd0;
      vld_q   <= 1'b0;
`ifdef YOLO_DEADLOCK_AUTO_REARM_EN
      evt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      det_q   <= det_d;
      mask_q  <= mask_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      beat_q  <= beat_d;
      vld_q   <= vld_d;
`ifdef YOLO_DEADLOCK_AUTO_REARM_EN
      evt_q   <= evt_d;
`endif
    end
  end

  // Report word mux; held stable by beat_q while the sink stalls.
  always_comb begin
    bus.rpt_data = 32'd0;
    if (vld_q) begin
      case (beat_q)
        2'd0:    bus.rpt_data = {16'hDEAD, 16'(mask_q)};
        2'd1:    bus.rpt_data = 32'(w1_q);
        default: bus.rpt_data = 32'(w2_q);
      endcase
    end
  end

  assign bus.rpt_last          = vld_q && (beat_q == 2'd2);
  assign bus.rpt_valid         = vld_q;
  assign bus.deadlock_detected = det_q;
  assign bus.deadlock_mask     = mask_q;
  assign bus.stall_cycles      = cnt_q;
`ifdef YOLO_DEADLOCK_AUTO_REARM_EN
  assign bus.event_cnt         = evt_q;
`endif
endmodule

// File: doc/yolo_max_pool_top_hls_deadlock_reporter.md
Name: yolo_max_pool_top_hls_deadlock_reporter

Overview:
- Consumer end of the HLS deadlock-monitor block flags. Takes the per-monitor `block` outputs of the max-pool top's deadlock monitors.
- Qualifies them: a deadlock is declared only after a block persists for a programmable number of consecutive cycles.
- Latches which monitors were blocked and counts stall cycles.
- Emits a 3-word report over a valid/ready stream for the PS/debug logger.

Parameters:
- NUM_MON, 2, number of monitor block inputs (1..16).
- THRESH, 1024, consecutive any-block cycles required to declare deadlock (>=2).
- CNT_W, 32, width of the stall counter and timestamp counter (4..32); saturating or wrapping as stated below.

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- mon_block  in  NUM_MON  block flags from the deadlock monitors, one bit per monitor.
- clear  in  1  pulse that re-arms the detector.
- deadlock_detected  out  1  sticky deadlock flag.
- deadlock_mask  out  NUM_MON  mon_block snapshot taken at the detection edge.
- stall_cycles  out  CNT_W  current consecutive any-block count, saturating.
- rpt_valid  out  1  report word valid.
- rpt_ready  in  1  report sink ready.
- rpt_data  out  32  report word.
- rpt_last  out  1  high on the final report word.

Behaviour:
- Reset: when ap_rst_n=0 at a rising edge, all outputs and state clear to 0 on that edge and state = IDLE. This takes precedence in every state, including mid-report; a partially sent report is abandoned.
- any_blk = OR of mon_block.
- Timestamp counter `ts`, CNT_W bits:
  - Increments every cycle out of reset.
  - Wraps to 0 after all-ones.
- stall_cycles:
  - In IDLE/WATCH: any_blk=1 -> min(cnt+1, all-ones); any_blk=0 -> 0.
  - In REPORT/HOLD: saturating increment while any_blk=1; holds its value while any_blk=0.
- State machine:
  - IDLE:
    - any_blk=1 -> WATCH, cnt<=1.
    - clear ignored (no effect).
  - WATCH:
    - any_blk=0 -> IDLE, cnt<=0.
    - any_blk=1 and cnt+1==THRESH -> REPORT. On that same edge: deadlock_detected<=1, deadlock_mask<=mon_block, word1 latched = THRESH, word2 latched = ts, rpt_valid<=1.
    - clear=1 -> IDLE, cnt<=0. clear has priority over detection.
  - REPORT: three beats.
    - beat0 = {16'hDEAD, mask zero-extended to 16}.
    - beat1 = latched stall count, zero-extended to 32.
    - beat2 = latched ts, zero-extended to 32; rpt_last=1 on this beat only.
    - A beat transfers when rpt_valid && rpt_ready. rpt_data and rpt_last are stable while valid && !ready.
    - After beat2 transfers: rpt_valid<=0 on the same edge, state -> HOLD.
    - clear ignored in REPORT.
  - HOLD:
    - deadlock_detected and deadlock_mask held.
    - clear=1 -> IDLE; deadlock_detected, deadlock_mask and cnt cleared on the same edge.
- Timing: deadlock_detected rises on the edge that samples the THRESH-th consecutive any_blk cycle. Detection latency from the first block cycle is THRESH edges.
- mon_block changes during WATCH do not restart the count as long as any_blk stays 1.
- Only one report per detection: no new detection is possible until back in IDLE.

Optional Feature:
- Macro: YOLO_DEADLOCK_AUTO_REARM_EN.
- Defined:
  - In HOLD, any_blk=0 for one sampled cycle -> IDLE; deadlock_detected, deadlock_mask and cnt clear on that edge (self-recovering stall).
  - Adds output `event_cnt`, 8 bits, saturating at 255: increments on each detection edge; reset to 0 only by ap_rst_n.
- Undefined:
  - HOLD exits only via clear or reset.
  - No event_cnt port.

Test Plan (NUM_MON=2, THRESH=8, CNT_W=32 unless stated):
- mon_block=01 for 7 cycles, then 00 -> deadlock_detected stays 0; stall_cycles goes 1..7 then 0; rpt_valid never asserts.
- mon_block=10 held, rpt_ready=1 -> deadlock_detected=1 on the 8th edge; deadlock_mask=10; then three consecutive beats:
  - 0xDEAD0002
  - 0x00000008
  - ts at detection, with rpt_last=1
  
  Then HOLD; stall_cycles keeps incrementing (9, 10, ...).
- Same as above with rpt_ready=0 for 5 cycles while beat1 is presented -> rpt_data stays 0x00000008 with rpt_valid=1 throughout; beat2 follows after ready returns; exactly 3 transfers total.
- In HOLD, pulse clear for one cycle -> next edge: deadlock_detected=0, mask=00, stall_cycles=0, state IDLE. A fresh 8-cycle block then re-detects.
- ap_rst_n=0 during beat1 -> next edge: rpt_valid=0, deadlock_detected=0, stall_cycles=0. After release, no residual beats are emitted.
- CNT_W=4, THRESH=8, block held 40 cycles -> stall_cycles saturates at 15 and stays there. Without YOLO_DEADLOCK_AUTO_REARM_EN, dropping block leaves deadlock_detected=1. With it defined, deadlock_detected clears one edge after any_blk=0 and event_cnt=1.
